i2c_data_out: RTL and testbench

- Slave-side transmit path for I2C master-read transactions; the read counterpart of the slave data-in decoder.
- Shifts a preloaded buffer of NUM_BYTES bytes MSB-first onto SDA by pulling the line low via SDA_down (open-drain), then releases SDA each 9th clock and samples the master's ACK/NACK.
- Runs on FPGA_clk and oversamples SCL/SDA using externally registered SCL_prev/SDA_prev, the same edge-detect scheme as the receive side.

---
 rtl/i2c_data_out.sv | 125 ++++++++++++
 tb/tb_i2c_data_out.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_data_out.sv
// I2C slave transmit path for master-read transactions: shifts a preloaded byte buffer
// MSB-first onto SDA (open-drain), releases SDA for the 9th clock and samples ACK/NACK.
module i2c_data_out #(
   parameter int unsigned NUM_BYTES = 6
) (
   input  logic                           FPGA_clk,
   input  logic                           rst,
   input  logic                           SCL,
   input  logic                           SCL_prev,
   input  logic                           SDA,
   input  logic                           SDA_prev,
   input  logic                           enable,
   input  logic                           load,
   input  logic [7:0]                     tx_data [NUM_BYTES-1:0],
   output logic                           SDA_down,
   output logic                           busy,
   output logic                           done,
   output logic                           nack,
   output logic [$clog2(NUM_BYTES+1)-1:0] byte_count
);

   localparam int unsigned CntW = $clog2(NUM_BYTES + 1);
   localparam int unsigned IdxW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

   typedef enum logic [2:0] {StIdle, StShift, StAck, StAckWait, StDone} state_e;

   state_e          state;
   logic [7:0]      tx_buf [NUM_BYTES-1:0];
   logic [IdxW-1:0] byte_idx;
   logic [IdxW-1:0] next_byte_idx;
   logic [2:0]      bit_idx;
   logic            acked;
   logic            first_msb;

   logic scl_rise, scl_fall, stop, start, abort;

   assign scl_rise = SCL & ~SCL_prev;
   assign scl_fall = ~SCL & SCL_prev;
   assign stop     = SCL & SCL_prev & SDA & ~SDA_prev;
   assign start    = SCL & SCL_prev & ~SDA & SDA_prev;
   assign abort    = stop | start | ~enable;

   assign next_byte_idx = (byte_idx == IdxW'(NUM_BYTES - 1)) ? '0 : byte_idx + 1'b1;
   // A load coinciding with the grant must still put the freshly loaded MSB on the bus.
   assign first_msb     = load ? tx_data[0][7] : tx_buf[0][7];
   assign busy          = (state != StIdle);

   always_ff @(posedge FPGA_clk or posedge rst) begin
      if (rst) begin
         state      <= StIdle;
         SDA_down   <= 1'b0;
         done       <= 1'b0;
         nack       <= 1'b0;
         byte_count <= '0;
         byte_idx   <= '0;
         bit_idx    <= 3'd7;
         acked      <= 1'b0;
         for (int i = 0; i < int'(NUM_BYTES); i++) tx_buf[i] <= 8'h00;
      end else begin
         done <= 1'b0;
         if (state != StIdle && abort) begin
            state    <= StIdle;
            SDA_down <= 1'b0;
         end else begin
            unique case (state)
               StIdle: begin
                  if (load) begin
                     for (int i = 0; i < int'(NUM_BYTES); i++) tx_buf[i] <= tx_data[i];
                  end
                  if (enable && !SCL) begin
                     state      <= StShift;
                     byte_idx   <= '0;
                     bit_idx    <= 3'd7;
                     SDA_down   <= ~first_msb;
                     nack       <= 1'b0;
                     byte_count <= '0;
                  end
               end
               StShift: begin
                  if (scl_fall) begin
                     if (bit_idx != 3'd0) begin
                        bit_idx  <= bit_idx - 3'd1;
                        SDA_down <= ~tx_buf[byte_idx][bit_idx - 3'd1];
                     end else begin
                        SDA_down <= 1'b0;
                        state    <= StAck;
                     end
                  end
               end
               StAck: begin
                  SDA_down <= 1'b0;
                  if (scl_rise) begin
                     acked <= ~SDA;
                     if (byte_count < CntW'(NUM_BYTES)) byte_count <= byte_count + 1'b1;
                     state <= StAckWait;
                  end
               end
               StAckWait: begin
                  if (scl_fall) begin
                     if (acked) begin
                        byte_idx <= next_byte_idx;
                        bit_idx  <= 3'd7;
                        SDA_down <= ~tx_buf[next_byte_idx][7];
                        state    <= StShift;
                     end else begin
                        done  <= 1'b1;
                        nack  <= 1'b1;
                        state <= StDone;
                     end
                  end
               end
               StDone: begin
                  SDA_down <= 1'b0;
                  state    <= StIdle;
               end
               default: begin
                  SDA_down <= 1'b0;
                  state    <= StIdle;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_data_out.sv
// Self-checking bench for i2c_data_out: a bench-side master clocks SCL through synchronizers,
// reads the open-drain bus and compares bits against a scoreboard queue.
module tb_i2c_data_out;

   localparam int unsigned NB   = 6;
   localparam int          HALF = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl_bus = 1'b1;
   logic       master_sda = 1'b1;
   logic       sda_bus;
   logic       scl_s = 1'b1, scl_p = 1'b1, sda_s = 1'b1, sda_p = 1'b1;
   logic       enable = 1'b0;
   logic       load = 1'b0;
   logic [7:0] tx_data [NB-1:0];
   logic       sda_down, busy, done, nack;
   logic [2:0] byte_count;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   logic exp_q [$];

   typedef struct {
      logic [7:0] bytes [NB];
      int         reads;
      int         exp_count;
   } vec_t;

   vec_t vecs [4];

   i2c_data_out #(.NUM_BYTES(NB)) dut (
      .FPGA_clk  (clk),
      .rst       (rst),
      .SCL       (scl_s),
      .SCL_prev  (scl_p),
      .SDA       (sda_s),
      .SDA_prev  (sda_p),
      .enable    (enable),
      .load      (load),
      .tx_data   (tx_data),
      .SDA_down  (sda_down),
      .busy      (busy),
      .done      (done),
      .nack      (nack),
      .byte_count(byte_count)
   );

   assign sda_bus = master_sda & ~sda_down;

   always #5 clk = ~clk;

   // Bus synchronizers feeding the DUT's SCL/SDA and their one-cycle-delayed copies.
   always @(posedge clk) begin
      scl_s <= scl_bus;
      scl_p <= scl_s;
      sda_s <= sda_bus;
      sda_p <= sda_s;
   end

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load_bytes(input logic [7:0] bytes [NB]);
      for (int i = 0; i < int'(NB); i++) tx_data[i] = bytes[i];
      load = 1'b1;
      tick(1);
      load = 1'b0;
   endtask

   task automatic push_byte(input logic [7:0] v, input int nbits);
      for (int b = 7; b > 7 - nbits; b--) exp_q.push_back(v[b]);
   endtask

   // Master reads n data bits, comparing bus SDA at each SCL rise against the scoreboard.
   task automatic data_bits(input int n);
      for (int b = 0; b < n; b++) begin
         tick(HALF);
         scl_bus = 1'b1;
         if (exp_q.size() == 0) check("scoreboard_underflow", 1, 0);
         else check("data_bit", sda_bus, exp_q.pop_front());
         tick(HALF);
         scl_bus = 1'b0;
      end
   endtask

   task automatic ack_bit(input bit nack_bit);
      tick(HALF / 2);
      master_sda = nack_bit;
      tick(HALF / 2);
      scl_bus = 1'b1;
      check("ack_slot_released", sda_down, 1'b0);
      tick(HALF);
      scl_bus = 1'b0;
      if (!nack_bit) begin
         tick(HALF / 2);
         master_sda = 1'b1;
      end
   endtask

   task automatic run_xfer(input logic [7:0] bytes [NB], input int reads, input bit do_load,
                           input int exp_count);
      int base;
      bit seen;
      scl_bus = 1'b0;
      tick(3);
      if (do_load) load_bytes(bytes);
      base   = done_cnt;
      enable = 1'b1;
      for (int k = 0; k < reads; k++) begin
         push_byte(bytes[k % int'(NB)], 8);
         data_bits(8);
         ack_bit(k == reads - 1);
         if (k == 0 && reads > 1) begin
            // Load pulse mid-transaction with different data must not disturb the buffer.
            for (int i = 0; i < int'(NB); i++) tx_data[i] = ~bytes[i];
            load = 1'b1;
            tick(1);
            load = 1'b0;
         end
      end
      seen = 1'b0;
      for (int t = 0; t < 6 && !seen; t++) begin
         tick(1);
         if (done === 1'b1) seen = 1'b1;
      end
      check("done_seen", seen, 1'b1);
      enable = 1'b0;
      tick(4);
      check("done_pulses", done_cnt - base, 1);
      check("nack_flag", nack, 1'b1);
      check("byte_count", byte_count, exp_count);
      check("busy_after", busy, 1'b0);
      check("queue_drained", exp_q.size(), 0);
   endtask

   initial begin
      logic [7:0] stop_bytes [NB];
      logic [7:0] rst_bytes  [NB];
      logic [7:0] zero_bytes [NB];
      logic [7:0] post_bytes [NB];
      int base;

      vecs[0].bytes = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      vecs[0].reads = 1; vecs[0].exp_count = 1;
      vecs[1].bytes = '{8'h3C, 8'hFF, 8'h00, 8'h12, 8'h34, 8'h56};
      vecs[1].reads = 3; vecs[1].exp_count = 3;
      vecs[2].bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      vecs[2].reads = 7; vecs[2].exp_count = 6;
      vecs[3].bytes = '{8'h81, 8'h7E, 8'hC3, 8'h3C, 8'h01, 8'h80};
      vecs[3].reads = 6; vecs[3].exp_count = 6;
      stop_bytes = '{8'h5A, 8'hD7, 8'h00, 8'h00, 8'h00, 8'h00};
      rst_bytes  = '{8'h0F, 8'hF0, 8'hAA, 8'h55, 8'hCC, 8'h33};
      zero_bytes = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      post_bytes = '{8'h96, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

      // Reset with garbage on the inputs.
      for (int i = 0; i < int'(NB); i++) tx_data[i] = 8'($urandom);
      enable  = 1'b1;
      load    = 1'b1;
      scl_bus = 1'b0;
      tick(2);
      check("rst_sda_down", sda_down, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_nack", nack, 1'b0);
      check("rst_byte_count", byte_count, 3'd0);
      enable = 1'b0;
      load   = 1'b0;
      tick(1);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick(HALF);
         scl_bus = ~scl_bus;
      end
      check("idle_without_enable", busy, 1'b0);
      scl_bus = 1'b1;
      tick(4);

      for (int v = 0; v < 4; v++) run_xfer(vecs[v].bytes, vecs[v].reads, 1'b1, vecs[v].exp_count);

      // Stop condition during bit 4 of the second byte (a released '1' bit).
      scl_bus = 1'b0;
      tick(3);
      load_bytes(stop_bytes);
      base   = done_cnt;
      enable = 1'b1;
      push_byte(stop_bytes[0], 8);
      push_byte(stop_bytes[1], 3);
      data_bits(8);
      ack_bit(1'b0);
      data_bits(3);
      tick(HALF / 2);
      master_sda = 1'b0;
      tick(HALF / 2);
      scl_bus = 1'b1;
      tick(HALF / 2);
      check("busy_before_stop", busy, 1'b1);
      master_sda = 1'b1;
      tick(2);
      check("stop_sda_down", sda_down, 1'b0);
      check("stop_busy", busy, 1'b0);
      check("stop_no_done", done_cnt - base, 0);
      check("stop_byte_count", byte_count, 3'd1);
      check("stop_nack_clear", nack, 1'b0);
      enable = 1'b0;
      tick(4);
      run_xfer(post_bytes, 1, 1'b1, 1);

      // Asynchronous reset between clock edges while SDA is being pulled low.
      scl_bus = 1'b0;
      tick(3);
      load_bytes(rst_bytes);
      enable = 1'b1;
      tick(3);
      check("pre_rst_sda_down", sda_down, 1'b1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_sda_down", sda_down, 1'b0);
      check("async_rst_busy", busy, 1'b0);
      enable = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(2);
      run_xfer(zero_bytes, 1, 1'b0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
